// File: rtl/draw_bg_scroll.sv
// Background generator: 2-stage timing pipeline with frame-synchronous pattern select and horizontal scroll.
// Optional border overlay is built in when DRAW_BG_BORDER_EN is defined.
module draw_bg_scroll #(
  parameter int HOR_PIX     = 1024,
  parameter int VER_PIX     = 768,
  parameter int TILE_LOG2   = 5,
  parameter int SCROLL_STEP = 1,
  parameter int FRAME_DIV   = 1,
  parameter int GRAD_SHIFT  = 6,
  parameter int BORDER_W    = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [10:0] hcount_i,
  input  logic [10:0] vcount_i,
  input  logic        hsync_i,
  input  logic        vsync_i,
  input  logic        hblnk_i,
  input  logic        vblnk_i,
  input  logic [11:0] rgb_i,
  output logic [10:0] hcount_o,
  output logic [10:0] vcount_o,
  output logic        hsync_o,
  output logic        vsync_o,
  output logic        hblnk_o,
  output logic        vblnk_o,
  output logic [11:0] rgb_o,
  input  logic [1:0]  mode_i,
  input  logic [11:0] colour_a_i,
  input  logic [11:0] colour_b_i,
  input  logic        scroll_en_i
);

  localparam int XW = TILE_LOG2 + 1;
  localparam int DW = (FRAME_DIV > 1) ? $clog2(FRAME_DIV) : 1;
  localparam logic [DW-1:0] DIV_LAST = DW'(FRAME_DIV - 1);

  // Frame strobe and shadow state
  logic          vblnk_q;
  logic          fs;
  logic [1:0]    mode_q;
  logic [11:0]   col_a_q;
  logic [11:0]   col_b_q;
  logic          scroll_en_q;
  logic          scroll_en_d;
  logic [DW-1:0] div_q;
  logic [DW-1:0] div_d;
  logic [XW-1:0] x_off_q;
  logic [XW-1:0] x_off_d;

  // Stage 1
  logic [10:0]   h1_q;
  logic [10:0]   v1_q;
  logic          hs1_q;
  logic          vs1_q;
  logic          hb1_q;
  logic          vb1_q;
  logic          blank1_q;
  logic          tx1_q;
  logic          ty1_q;
  logic [3:0]    g1_q;
  logic [11:0]   hx;
  logic          border1_d;
  logic [11:0]   bcol1_d;
  logic          border1_q;
  logic [11:0]   bcol1_q;

  // Stage 2
  logic [11:0]   pat;
  logic [11:0]   rgb_d;

  assign fs = vblnk_i & ~vblnk_q;

  always_comb begin
    scroll_en_d = fs ? scroll_en_i : scroll_en_q;
    div_d       = div_q;
    x_off_d     = x_off_q;
    if (fs) begin
      if (div_q == DIV_LAST) begin
        div_d = '0;
        // Offset wraps modulo one pattern period by its width alone.
        if (scroll_en_d) x_off_d = x_off_q + XW'(SCROLL_STEP);
      end else begin
        div_d = div_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vblnk_q     <= 1'b0;
      mode_q      <= 2'd0;
      col_a_q     <= 12'h000;
      col_b_q     <= 12'h000;
      scroll_en_q <= 1'b0;
      div_q       <= '0;
      x_off_q     <= '0;
    end else begin
      vblnk_q     <= vblnk_i;
      scroll_en_q <= scroll_en_d;
      div_q       <= div_d;
      x_off_q     <= x_off_d;
      if (fs) begin
        mode_q  <= mode_i;
        col_a_q <= colour_a_i;
        col_b_q <= colour_b_i;
      end
    end
  end

  assign hx = {1'b0, hcount_i} + 12'(x_off_q);

`ifdef DRAW_BG_BORDER_EN
  always_comb begin
    border1_d = 1'b1;
    bcol1_d   = 12'h000;
    if (vcount_i < 11'(BORDER_W))                  bcol1_d = 12'hff0;
    else if (vcount_i >= 11'(VER_PIX - BORDER_W))  bcol1_d = 12'hf00;
    else if (hcount_i < 11'(BORDER_W))             bcol1_d = 12'h0f0;
    else if (hcount_i >= 11'(HOR_PIX - BORDER_W))  bcol1_d = 12'h00f;
    else                                           border1_d = 1'b0;
  end
`else
  localparam int UNUSED_GEOM = HOR_PIX + VER_PIX + BORDER_W;
  assign border1_d = 1'b0;
  assign bcol1_d   = 12'h000;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      h1_q      <= '0;
      v1_q      <= '0;
      hs1_q     <= 1'b0;
      vs1_q     <= 1'b0;
      hb1_q     <= 1'b0;
      vb1_q     <= 1'b0;
      blank1_q  <= 1'b0;
      tx1_q     <= 1'b0;
      ty1_q     <= 1'b0;
      g1_q      <= 4'd0;
      border1_q <= 1'b0;
      bcol1_q   <= 12'h000;
    end else begin
      h1_q      <= hcount_i;
      v1_q      <= vcount_i;
      hs1_q     <= hsync_i;
      vs1_q     <= vsync_i;
      hb1_q     <= hblnk_i;
      vb1_q     <= vblnk_i;
      blank1_q  <= hblnk_i | vblnk_i;
      tx1_q     <= hx[TILE_LOG2];
      ty1_q     <= vcount_i[TILE_LOG2];
      g1_q      <= vcount_i[GRAD_SHIFT+3 -: 4];
      border1_q <= border1_d;
      bcol1_q   <= bcol1_d;
    end
  end

  always_comb begin
    pat = col_a_q;
    case (mode_q)
      2'd0:    pat = col_a_q;
      2'd1:    pat = (tx1_q ^ ty1_q) ? col_b_q : col_a_q;
      2'd2:    pat = {g1_q, g1_q, g1_q};
      default: pat = tx1_q ? col_b_q : col_a_q;
    endcase
  end

  always_comb begin
    rgb_d = pat;
    if (blank1_q)       rgb_d = 12'h000;
    else if (border1_q) rgb_d = bcol1_q;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hcount_o <= '0;
      vcount_o <= '0;
      hsync_o  <= 1'b0;
      vsync_o  <= 1'b0;
      hblnk_o  <= 1'b0;
      vblnk_o  <= 1'b0;
      rgb_o    <= 12'h000;
    end else begin
      hcount_o <= h1_q;
      vcount_o <= v1_q;
      hsync_o  <= hs1_q;
      vsync_o  <= vs1_q;
      hblnk_o  <= hb1_q;
      vblnk_o  <= vb1_q;
      rgb_o    <= rgb_d;
    end
  end

  // Incoming colour is replaced entirely; only one bit of hx selects the tile.
  logic unused_bits;
  assign unused_bits = ^{rgb_i, hx[11:TILE_LOG2+1], hx[TILE_LOG2-1:0]};

endmodule

// File: tb/tb_draw_bg_scroll.sv
// Directed bench for draw_bg_scroll: reset, latency, patterns, frame-synchronous updates, scroll, border.
module tb_draw_bg_scroll;

`ifdef DRAW_BG_BORDER_EN
  localparam bit BORDER = 1'b1;
`else
  localparam bit BORDER = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic [10:0] hcount_i, vcount_i;
  logic        hsync_i, vsync_i, hblnk_i, vblnk_i;
  logic [11:0] rgb_i;
  logic [10:0] hcount_o, vcount_o;
  logic        hsync_o, vsync_o, hblnk_o, vblnk_o;
  logic [11:0] rgb_o;
  logic [1:0]  mode_i;
  logic [11:0] colour_a_i, colour_b_i;
  logic        scroll_en_i;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  draw_bg_scroll #(
    .HOR_PIX(1024), .VER_PIX(768), .TILE_LOG2(5), .SCROLL_STEP(1),
    .FRAME_DIV(2), .GRAD_SHIFT(6), .BORDER_W(2)
  ) dut (
    .clk(clk), .rst(rst),
    .hcount_i(hcount_i), .vcount_i(vcount_i),
    .hsync_i(hsync_i), .vsync_i(vsync_i), .hblnk_i(hblnk_i), .vblnk_i(vblnk_i),
    .rgb_i(rgb_i),
    .hcount_o(hcount_o), .vcount_o(vcount_o),
    .hsync_o(hsync_o), .vsync_o(vsync_o), .hblnk_o(hblnk_o), .vblnk_o(vblnk_o),
    .rgb_o(rgb_o),
    .mode_i(mode_i), .colour_a_i(colour_a_i), .colour_b_i(colour_b_i),
    .scroll_en_i(scroll_en_i)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic drive(input int h, input int v, input logic hb, input logic vb);
    hcount_i = 11'(h);
    vcount_i = 11'(v);
    hsync_i  = hcount_i[0];
    vsync_i  = vcount_i[1];
    hblnk_i  = hb;
    vblnk_i  = vb;
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  // vblnk rises on the second drive; afterwards the output holds that blanked pixel.
  task automatic strobe();
    drive(1024, 767, 1'b1, 1'b0); tick();
    drive(0, 768, 1'b1, 1'b1);    tick(); tick();
  endtask

  task automatic pix(input string tag, input int h, input int v, input logic [11:0] exp);
    drive(h, v, (h >= 1024), 1'b0);
    tick(); tick();
    check(tag, {52'd0, rgb_o}, {52'd0, exp});
  endtask

  initial begin
    rst = 1'b1;
    rgb_i = 12'habc;
    mode_i = 2'd1; colour_a_i = 12'h123; colour_b_i = 12'h456; scroll_en_i = 1'b1;
    drive(300, 200, 1'b0, 1'b0);
    tick(); tick();
    check("reset_outputs", {26'd0, hcount_o, vcount_o, hsync_o, vsync_o, hblnk_o, vblnk_o, rgb_o}, 64'd0);
    rst = 1'b0;

    mode_i = 2'd0; colour_a_i = 12'h123; scroll_en_i = 1'b0;
    pix("pre_fs_black", 10, 10, 12'h000);

    strobe();
    check("vblank_black", {52'd0, rgb_o}, 64'd0);
    check("vblank_flag", {63'd0, vblnk_o}, 64'd1);

    drive(10, 10, 1'b0, 1'b0); tick();
    check("lat_not_yet", {53'd0, vcount_o}, 64'd768);
    drive(11, 10, 1'b0, 1'b0); tick();
    check("lat_hcount", {53'd0, hcount_o}, 64'd10);
    check("lat_vcount", {53'd0, vcount_o}, 64'd10);
    check("lat_rgb", {52'd0, rgb_o}, 64'h123);
    check("lat_syncblank", {60'd0, hsync_o, vsync_o, hblnk_o, vblnk_o}, 64'b0100);
    tick();
    check("lat_next_h", {52'd0, hcount_o, hsync_o}, {52'd0, 11'd11, 1'b1});
    pix("hblank_black", 1100, 10, 12'h000);

    mode_i = 2'd1; colour_a_i = 12'h000; colour_b_i = 12'hfff;
    strobe();
    pix("chk_0_0", 0, 0, BORDER ? 12'hff0 : 12'h000);
    pix("chk_31_0", 31, 0, BORDER ? 12'hff0 : 12'h000);
    pix("chk_32_0", 32, 0, BORDER ? 12'hff0 : 12'hfff);
    pix("chk_32_32", 32, 32, 12'h000);
    pix("chk_40_5", 40, 5, 12'hfff);
    pix("chk_100_299", 100, 299, 12'h000);
    mode_i = 2'd2;
    pix("mid_still_chk_a", 64, 300, 12'hfff);
    pix("mid_still_chk_b", 32, 300, 12'h000);

    strobe();
    pix("grad_320", 100, 320, 12'h555);
    pix("grad_64", 100, 64, 12'h111);
    pix("grad_700", 100, 700, 12'haaa);

    drive(1024, 767, 1'b1, 1'b0); tick();
    drive(0, 768, 1'b1, 1'b1);    tick();
    mode_i = 2'd3;
    tick();
    pix("late_change_ignored", 100, 320, 12'h555);

    colour_b_i = 12'h777;
    drive(1024, 767, 1'b1, 1'b0); tick();
    drive(0, 768, 1'b1, 1'b1);
    colour_b_i = 12'hfff; scroll_en_i = 1'b1;
    tick(); tick();
    pix("same_cycle_capture", 32, 100, 12'hfff);
    pix("scroll0_31", 31, 100, 12'h000);

    strobe();
    pix("scroll1_31", 31, 100, 12'hfff);
    pix("scroll1_30", 30, 100, 12'h000);
    strobe();
    pix("div_hold_31", 31, 100, 12'hfff);
    strobe();
    pix("scroll2_30", 30, 100, 12'hfff);
    pix("scroll2_29", 29, 100, 12'h000);

    for (int i = 0; i < 58; i++) strobe();
    pix("xoff31_h1", 1, 100, BORDER ? 12'h0f0 : 12'hfff);
    pix("xoff31_h0", 0, 100, BORDER ? 12'h0f0 : 12'h000);
    pix("xoff31_h33", 33, 100, 12'h000);
    pix("xoff31_h32", 32, 100, 12'hfff);

    for (int i = 0; i < 66; i++) strobe();
    pix("wrap_h31", 31, 100, 12'h000);
    pix("wrap_h32", 32, 100, 12'hfff);

    strobe(); strobe();
    pix("pre_rst_xoff1", 31, 100, 12'hfff);
    drive(500, 100, 1'b0, 1'b0); tick();
    #2 rst = 1'b1;
    #1 check("rst_async", {26'd0, hcount_o, vcount_o, hsync_o, vsync_o, hblnk_o, vblnk_o, rgb_o}, 64'd0);
    @(negedge clk);
    rst = 1'b0;
    scroll_en_i = 1'b0;
    pix("post_rst_black", 40, 100, 12'h000);
    strobe();
    pix("post_rst_xoff0_31", 31, 100, 12'h000);
    pix("post_rst_xoff0_32", 32, 100, 12'hfff);

    mode_i = 2'd0; colour_a_i = 12'h5a5;
    strobe();
    pix("brd_top", 0, 0, BORDER ? 12'hff0 : 12'h5a5);
    pix("brd_bottom", 1, 767, BORDER ? 12'hf00 : 12'h5a5);
    pix("brd_left", 1, 100, BORDER ? 12'h0f0 : 12'h5a5);
    pix("brd_right", 1022, 100, BORDER ? 12'h00f : 12'h5a5);
    pix("brd_inside_tl", 2, 2, 12'h5a5);
    pix("brd_inside_br", 1021, 765, 12'h5a5);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/draw_bg_scroll.md
# draw_bg_scroll

Parametrised background generator and successor to the fixed grey-with-edge-lines background stage. It sits first in the VGA drawing chain, directly after the timing generator. It passes timing through a 2-stage pipeline and replaces `rgb` with one of four selectable patterns. Pattern selection and a horizontal scroll offset are updated only once per frame, so they never tear mid-frame.

## Interface
Parameters:
- `HOR_PIX`, default 1024: active pixels per line.
- `VER_PIX`, default 768: active lines per frame.
- `TILE_LOG2`, default 5: log2 of tile/stripe size in pixels (32 px).
- `SCROLL_STEP`, default 1: pixels added to the offset per scroll update.
- `FRAME_DIV`, default 1: frames per scroll update (≥1).
- `GRAD_SHIFT`, default 6: `vcount` right-shift that gives the 4-bit gradient level.
- `BORDER_W`, default 1: border thickness in pixels (used only with the macro).

Ports (clock and reset are one clock, asynchronous active-high reset):
- `clk`  in  1  pixel clock.
- `rst`  in  1  asynchronous, active-high reset.
- `in`  vga_if.in  –  timing in: `hcount`/`vcount` 11 b, `hsync`, `vsync`, `hblnk`, `vblnk`, `rgb` 12 b (input `rgb` ignored).
- `out`  vga_if.out  –  timing delayed 2 cycles, plus generated `rgb`.
- `mode`  in  2  pattern select: 0 solid, 1 checkerboard, 2 vertical gradient, 3 vertical stripes.
- `colour_a`  in  12  primary colour.
- `colour_b`  in  12  secondary colour.
- `scroll_en`  in  1  enables the scroll offset to advance.

## Operation
- **Frame strobe**: `fs` = rising edge of `in.vblnk`, detected with a registered copy of `vblnk`.
- **On `fs`**:
  - `mode`, `colour_a`, `colour_b` and `scroll_en` are latched into shadow registers. Only the shadows drive pattern generation.
  - The frame divider counter (0..FRAME_DIV-1) advances. At terminal count it wraps to 0. If the latched `scroll_en`=1 at that point, `x_off` += SCROLL_STEP.
- **Offset width**: `x_off` is TILE_LOG2+1 bits and wraps naturally modulo 2^(TILE_LOG2+1), which is one full pattern period.
- **Stage 1**: register timing. Compute `hx = in.hcount + x_off` (12 b, no overflow), tile bits `tx = hx[TILE_LOG2]`, `ty = vcount[TILE_LOG2]`, gradient level `g = vcount[GRAD_SHIFT+3:GRAD_SHIFT]`, blank flag, and the border flag.
- **Stage 2**: select `rgb`:
  - Blank (`hblnk` | `vblnk`): 12'h000.
  - Mode 0: `colour_a`.
  - Mode 1: `tx^ty` ? `colour_b` : `colour_a`.
  - Mode 2: {g,g,g}.
  - Mode 3: `tx` ? `colour_b` : `colour_a`.
- Modes 0 and 2 ignore `x_off`. The offset keeps advancing regardless of mode.
- **Reset**: all `out` fields 0, shadows 0 (mode 0, colours 000, `scroll_en` 0), `x_off` 0, divider 0, `vblnk` history 0. Reset asserted mid-frame clears immediately. After release, output is solid 000 until the first `fs` latches real inputs.
- **Simultaneous events**: a change of `mode` or the colours in the same cycle as `fs` is captured. A change one cycle after `fs` waits for the next frame.

## Timing
- Latency is exactly 2 `clk` cycles from `in` to `out` for every field. Sync, blank, counts and `rgb` stay mutually aligned.
- Shadow registers and `x_off` update in the cycle after the `fs` edge. That cycle lies inside vertical blanking, so no visible pixel uses mixed state.
- A scroll update occurs every FRAME_DIV frames. With FRAME_DIV=1 it occurs every frame.
- Throughput is one pixel per clock, with no stalls.

## Configuration
- **`DRAW_BG_BORDER_EN`** defined: active pixels within BORDER_W of an edge override the pattern. Priority order:
  - top (vcount<BORDER_W): 12'hff0
  - bottom (vcount≥VER_PIX-BORDER_W): 12'hf00
  - left (hcount<BORDER_W): 12'h0f0
  - right (hcount≥HOR_PIX-BORDER_W): 12'h00f
- **Not defined**: no border logic. The pattern covers the whole active area.

## Test plan
- **Reset mid-frame**: assert `rst` asynchronously at hcount=500. All `out` fields read 0 before the next `clk` edge. `x_off`=0 after release.
- **Latency**: mode 0, `colour_a`=12'h123. The `in` field at hcount=10, vcount=10 appears on `out` 2 cycles later with rgb=12'h123. rgb=000 during blanking.
- **Checkerboard**: mode 1, a=000, b=fff, `scroll_en`=0, TILE_LOG2=5:
  - (h=0, v=0) → 000
  - (31, 0) → 000
  - (32, 0) → fff
  - (32, 32) → 000
- **Scrolling**: mode 3, `scroll_en`=1, FRAME_DIV=2, SCROLL_STEP=1. `x_off` goes 0,0,1,1,2… across frames. After 128 frames it wraps to 0. With `x_off`=31, h=1 gives hx=32 → `colour_b`.
- **Mid-frame mode change**: switch `mode` 1→2 at vcount=300. The rest of the frame stays checkerboard. The next frame is a gradient with level = vcount[9:6] (v=320 → rgb 12'h555).
- **Border**: with `DRAW_BG_BORDER_EN` and BORDER_W=2, pixel (0,0) → ff0, (1,767) → f00, (1,100) → 0f0, (1022,100) → 00f. Rebuilt without the macro, those pixels show the pattern colour.
